// File: rtl/tt_slot_pkg.sv
// tt_slot_pkg -- shared constants and types for the project slot scheduler.
//   IW_W / OW_W    : widths of the host->slot and slot->host buses
//   IW_* / OW_*    : bit offsets of the fields inside those buses
//   state_t        : scheduler FSM states
package tt_slot_pkg;

   localparam int IW_W       = 18;
   localparam int OW_W       = 24;
   localparam int FLD_W      = 8;

   // iw = {uio_in, ui_in, rst_n, clk}
   localparam int IW_CLK     = 0;
   localparam int IW_RST_N   = 1;
   localparam int IW_UI      = 2;
   localparam int IW_UIO     = 10;

   // ow = {uio_oe, uio_out, uo_out}
   localparam int OW_UO      = 0;
   localparam int OW_UIO_OUT = 8;
   localparam int OW_UIO_OE  = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DISABLE = 2'd1,
      ST_RESET   = 2'd2,
      ST_RUN     = 2'd3
   } state_t;

endpackage

// File: rtl/tt_slot_ow_mux.sv
// tt_slot_ow_mux -- N:1 selector for the per-slot 24-bit output bus.
//   slot_ow : packed outputs of all slots, slot k at [24k+23:24k]
//   sel     : slot index to forward
//   en      : when 0 the output is forced to zero
//   ow      : selected slot output
// Optional build macro OW_OE_MASK_EN: uio_out bits are ANDed with the
// slot's uio_oe bits so undriven pins read as 0; uio_oe and uo_out pass.
module tt_slot_ow_mux
   import tt_slot_pkg::*;
#(
   parameter int N_SLOTS = 16
) (
   input  logic [OW_W*N_SLOTS-1:0] slot_ow,
   input  logic [3:0]              sel,
   input  logic                    en,
   output logic [OW_W-1:0]         ow
);

   logic [OW_W-1:0] picked;

   always_comb begin
      picked = '0;
      for (int k = 0; k < N_SLOTS; k++) begin
         if (sel == 4'(k)) picked = slot_ow[k*OW_W +: OW_W];
      end
   end

   always_comb begin
      ow = '0;
      if (en) begin
         ow = picked;
`ifdef OW_OE_MASK_EN
         ow[OW_UIO_OUT +: FLD_W] = picked[OW_UIO_OUT +: FLD_W] & picked[OW_UIO_OE +: FLD_W];
`endif
      end
   end

endmodule

// File: rtl/tt_slot_sched.sv
// tt_slot_sched -- selects one of N_SLOTS project slots, sequencing a
// disable cycle and a reset hold before connecting it to the host.
//   clk, rst (async, active-high)
//   sel_valid/sel_ready/sel_addr/sel_off : slot-change request handshake
//   host_iw  -> slot_iw  : host inputs broadcast to slots (gated per state)
//   slot_ena             : one-hot (or zero) slot enable
//   slot_ow  -> host_ow  : selected slot outputs, combinational, RUN only
//   active               : 1 in RUN
//   cur_addr             : latched slot index
// Optional build macro OW_OE_MASK_EN (see tt_slot_ow_mux).
module tt_slot_sched
   import tt_slot_pkg::*;
#(
   parameter int N_SLOTS    = 16,
   parameter int RST_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sel_valid,
   output logic                    sel_ready,
   input  logic [3:0]              sel_addr,
   input  logic                    sel_off,
   input  logic [IW_W-1:0]         host_iw,
   output logic [IW_W-1:0]         slot_iw,
   output logic [N_SLOTS-1:0]      slot_ena,
   input  logic [OW_W*N_SLOTS-1:0] slot_ow,
   output logic [OW_W-1:0]         host_ow,
   output logic                    active,
   output logic [3:0]              cur_addr
);

   state_t     state;
   logic [7:0] cnt;
   logic       go_idle;   // DISABLE leads back to IDLE instead of RESET
   logic       accept;
   logic       req_ok;
   logic [N_SLOTS-1:0] sel_onehot;

   assign sel_ready = (state == ST_IDLE) || (state == ST_RUN);
   assign accept    = sel_valid && sel_ready;
   // Widened compare keeps the check meaningful when N_SLOTS = 16.
   assign req_ok    = !sel_off && ({1'b0, sel_addr} < 5'(N_SLOTS));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         cur_addr <= '0;
         go_idle  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept && req_ok) begin
                  cur_addr <= sel_addr;
                  go_idle  <= 1'b0;
                  state    <= ST_DISABLE;
               end
            end
            ST_DISABLE: begin
               if (go_idle) begin
                  state <= ST_IDLE;
               end else begin
                  state <= ST_RESET;
                  cnt   <= 8'(RST_CYCLES - 1);
               end
            end
            ST_RESET: begin
               // Hold ends on the cycle the counter reads zero; no wrap.
               if (cnt == 8'd0) state <= ST_RUN;
               else             cnt   <= cnt - 8'd1;
            end
            ST_RUN: begin
               if (accept) begin
                  state <= ST_DISABLE;
                  if (req_ok) begin
                     cur_addr <= sel_addr;
                     go_idle  <= 1'b0;
                  end else begin
                     go_idle  <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // cur_addr is only ever loaded with an in-range index, so this is one-hot.
   assign sel_onehot = N_SLOTS'(1) << cur_addr;
   assign active     = (state == ST_RUN);
   assign slot_ena   = ((state == ST_RESET) || (state == ST_RUN)) ? sel_onehot : '0;

   always_comb begin
      slot_iw = '0;
      if (state == ST_RESET) begin
         slot_iw           = host_iw;
         slot_iw[IW_RST_N] = 1'b0;
      end else if (state == ST_RUN) begin
         slot_iw = host_iw;
      end
   end

   tt_slot_ow_mux #(
      .N_SLOTS (N_SLOTS)
   ) u_ow_mux (
      .slot_ow (slot_ow),
      .sel     (cur_addr),
      .en      (active),
      .ow      (host_ow)
   );

endmodule

// File: tb/tb_tt_slot_sched.sv
// tb_tt_slot_sched -- directed scoreboard bench for tt_slot_sched
// (N_SLOTS=16, RST_CYCLES=4). Expected per-cycle outputs are queued as
// each request is driven and popped at every falling clock edge.
module tb_tt_slot_sched;

   localparam int NS  = 16;
   localparam int RC  = 4;
   localparam logic [17:0] HIW = 18'h35A5F;   // rst_n bit (bit1) is 1

   logic            clk = 1'b0;
   logic            rst;
   logic            sel_valid;
   logic            sel_ready;
   logic [3:0]      sel_addr;
   logic            sel_off;
   logic [17:0]     host_iw;
   logic [17:0]     slot_iw;
   logic [NS-1:0]   slot_ena;
   logic [24*NS-1:0] slot_ow;
   logic [23:0]     host_ow;
   logic            active;
   logic [3:0]      cur_addr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [15:0] ena;
      logic [17:0] iw;
      logic [23:0] ow;
      logic        act;
      logic        rdy;
      logic [3:0]  addr;
      logic        ck_addr;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   tt_slot_sched #(.N_SLOTS(NS), .RST_CYCLES(RC)) dut (
      .clk       (clk),
      .rst       (rst),
      .sel_valid (sel_valid),
      .sel_ready (sel_ready),
      .sel_addr  (sel_addr),
      .sel_off   (sel_off),
      .host_iw   (host_iw),
      .slot_iw   (slot_iw),
      .slot_ena  (slot_ena),
      .slot_ow   (slot_ow),
      .host_ow   (host_ow),
      .active    (active),
      .cur_addr  (cur_addr)
   );

   function automatic logic [23:0] raw_ow(int k);
      if (k == 5) return {8'h0F, 8'hFF, 8'hA5};
      return {8'(16*k + 1), 8'(8'h30 + k), 8'(8'h50 + k)};
   endfunction

   function automatic logic [23:0] exp_ow(int k);
      logic [23:0] r;
      r = raw_ow(k);
`ifdef OW_OE_MASK_EN
      r[15:8] = r[15:8] & r[23:16];
`endif
      return r;
   endfunction

   task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(string tag, logic [15:0] ena, logic [17:0] iw, logic [23:0] ow,
                       logic act, logic rdy, logic [3:0] addr, logic ck_addr);
      exp_t e;
      e.tag = tag; e.ena = ena; e.iw = iw; e.ow = ow;
      e.act = act; e.rdy = rdy; e.addr = addr; e.ck_addr = ck_addr;
      sb.push_back(e);
   endtask

   task automatic push_idle(string tag, logic [3:0] addr, logic ck_addr);
      push(tag, 16'h0, 18'h0, 24'h0, 1'b0, 1'b1, addr, ck_addr);
   endtask

   task automatic push_dis(string tag, logic [3:0] addr);
      push(tag, 16'h0, 18'h0, 24'h0, 1'b0, 1'b0, addr, 1'b1);
   endtask

   task automatic push_rst(string tag, logic [3:0] addr, int n);
      repeat (n) push(tag, 16'h1 << addr, HIW & ~18'h2, 24'h0, 1'b0, 1'b0, addr, 1'b1);
   endtask

   task automatic push_run(string tag, logic [3:0] addr, int n);
      repeat (n) push(tag, 16'h1 << addr, HIW, exp_ow(int'(addr)), 1'b1, 1'b1, addr, 1'b1);
   endtask

   task automatic compare_now();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL sb_underflow: got empty queue expected an entry");
      end else begin
         e = sb.pop_front();
         cmp({e.tag, ".ena"},    32'(slot_ena),  32'(e.ena));
         cmp({e.tag, ".iw"},     32'(slot_iw),   32'(e.iw));
         cmp({e.tag, ".ow"},     32'(host_ow),   32'(e.ow));
         cmp({e.tag, ".active"}, 32'(active),    32'(e.act));
         cmp({e.tag, ".ready"},  32'(sel_ready), 32'(e.rdy));
         if (e.ck_addr) cmp({e.tag, ".addr"}, 32'(cur_addr), 32'(e.addr));
      end
   endtask

   task automatic chk(int n);
      repeat (n) begin
         @(negedge clk);
         compare_now();
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int k = 0; k < NS; k++) slot_ow[k*24 +: 24] = raw_ow(k);
      host_iw   = HIW;
      rst       = 1'b1;
      sel_valid = 1'b0;
      sel_addr  = 4'd0;
      sel_off   = 1'b0;

      // Reset values
      push_idle("reset", 4'd0, 1'b1);
      chk(1);
      next_cycle();
      rst = 1'b0;

      // Scenario 1: select slot 3 from IDLE
      sel_valid = 1'b1; sel_addr = 4'd3;
      push_idle("s1_idle", 4'd0, 1'b1);
      chk(1);
      next_cycle();
      sel_valid = 1'b0;
      push_dis("s1_dis", 4'd3);
      push_rst("s1_rst", 4'd3, RC);
      push_run("s1_run", 4'd3, 2);
      chk(RC + 3);

      // Scenario 2: RUN on 3, switch to 9
      next_cycle();
      sel_valid = 1'b1; sel_addr = 4'd9;
      push_run("s2_pre", 4'd3, 1);
      chk(1);
      next_cycle();
      sel_valid = 1'b0;
      push_dis("s2_dis", 4'd9);
      push_rst("s2_rst", 4'd9, RC);
      push_run("s2_run", 4'd9, 2);
      chk(RC + 3);

      // Same-slot reselect, then a request held through DISABLE/RESET
      next_cycle();
      sel_valid = 1'b1; sel_addr = 4'd9;
      push_run("s3_pre", 4'd9, 1);
      chk(1);
      next_cycle();
      sel_addr = 4'd2;            // stays valid while not ready
      push_dis("s3_dis", 4'd9);
      push_rst("s3_hold", 4'd9, RC);
      push_run("s3_run1", 4'd9, 1);
      chk(RC + 2);
      next_cycle();
      sel_valid = 1'b0;
      push_dis("s3_dis2", 4'd2);
      push_rst("s3_rst2", 4'd2, RC);
      push_run("s3_run2", 4'd2, 1);
      chk(RC + 2);

      // Scenario 4: sel_off in RUN
      next_cycle();
      sel_valid = 1'b1; sel_off = 1'b1; sel_addr = 4'd5;
      push_run("s4_pre", 4'd2, 1);
      chk(1);
      next_cycle();
      sel_valid = 1'b0; sel_off = 1'b0;
      push_dis("s4_dis", 4'd2);
      push_idle("s4_idle", 4'd0, 1'b0);
      push_idle("s4_idle", 4'd0, 1'b0);
      chk(3);

      // sel_off in IDLE: consumed, stays IDLE
      next_cycle();
      sel_valid = 1'b1; sel_off = 1'b1; sel_addr = 4'd7;
      push_idle("idle_off", 4'd0, 1'b0);
      chk(1);
      next_cycle();
      sel_valid = 1'b0; sel_off = 1'b0;
      push_idle("idle_off2", 4'd0, 1'b0);
      push_idle("idle_off3", 4'd0, 1'b0);
      chk(2);

      // Scenario 6: slot 5 output (mask applies when enabled)
      next_cycle();
      sel_valid = 1'b1; sel_addr = 4'd5;
      push_idle("s6_idle", 4'd0, 1'b0);
      chk(1);
      next_cycle();
      sel_valid = 1'b0;
      push_dis("s6_dis", 4'd5);
      push_rst("s6_rst", 4'd5, RC);
      push_run("s6_run", 4'd5, 1);
      chk(RC + 2);

      // Scenario 5: asynchronous reset in the middle of the reset hold
      next_cycle();
      sel_valid = 1'b1; sel_addr = 4'd7;
      push_run("s5_pre", 4'd5, 1);
      chk(1);
      next_cycle();
      sel_valid = 1'b0;
      push_dis("s5_dis", 4'd7);
      push_rst("s5_rst", 4'd7, 2);
      chk(3);
      #2;
      rst = 1'b1;
      #1;
      push_idle("s5_async", 4'd0, 1'b1);
      compare_now();
      next_cycle();
      rst = 1'b0;
      push_idle("s5_after", 4'd0, 1'b1);
      push_idle("s5_after", 4'd0, 1'b1);
      push_idle("s5_after", 4'd0, 1'b1);
      chk(3);

      cmp("sb_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
